display_fill: RTL and testbench

DISPLAY_FILL -- requirements
Module: display_fill

---
 rtl/display_fill_pkg.sv | 25 ++
 rtl/fill_scan.sv | 76 +++++++
 rtl/display_fill.sv | 108 ++++++++++
 tb/tb_display_fill.sv | 136 +++++++++++++
 4 files changed

// File: rtl/display_fill_pkg.sv
// Shared display constants, the fill FSM state type and the start-of-row address helper.
package display_fill_pkg;

    localparam int H_RES_C = 80;
    localparam int V_RES_C = 60;
    localparam int X_W     = 7;
    localparam int Y_W     = 6;
    localparam int EXT_W   = 8;
    localparam int ADDR_W  = 13;
    localparam int COLOR_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    // Product with a constant width, evaluated only when a command is loaded.
    function automatic logic [ADDR_W-1:0] row_base(input logic [Y_W-1:0] y, input int h_res);
        logic [31:0] p;
        p = 32'(y) * 32'(h_res);
        return p[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/fill_scan.sv
// Row-major rectangle walker: presents the pixel to emit this cycle and advances when it is taken.
// On load, the start pixel is presented in the same cycle; a stall holds the current pixel.
module fill_scan
    import display_fill_pkg::*;
#(
    parameter int H_RES = H_RES_C
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              run_i,
    input  logic              stall_i,
    input  logic [X_W-1:0]    x_i,
    input  logic [Y_W-1:0]    y_i,
    input  logic [EXT_W-1:0]  x_end_i,
    input  logic [EXT_W-1:0]  y_end_i,
    output logic              emit_o,
    output logic              last_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [X_W-1:0]    col_q, col_d, col_c, x0_q, x0_d, x0_c;
    logic [Y_W-1:0]    row_q, row_d, row_c;
    logic [ADDR_W-1:0] base_q, base_d, base_c;
    logic [EXT_W-1:0]  x_end_q, x_end_d, xe_c, y_end_q, y_end_d, ye_c;
    logic              col_wrap;

    always_comb begin
        col_c    = load_i ? x_i : col_q;
        row_c    = load_i ? y_i : row_q;
        base_c   = load_i ? row_base(y_i, H_RES) : base_q;
        x0_c     = load_i ? x_i : x0_q;
        xe_c     = load_i ? x_end_i : x_end_q;
        ye_c     = load_i ? y_end_i : y_end_q;

        col_wrap = (EXT_W'(col_c) + EXT_W'(1)) == xe_c;
        last_o   = col_wrap && ((EXT_W'(row_c) + EXT_W'(1)) == ye_c);
        emit_o   = (load_i || run_i) && !stall_i;
        addr_o   = base_c + ADDR_W'(col_c);

        col_d    = col_c;
        row_d    = row_c;
        base_d   = base_c;
        x0_d     = x0_c;
        x_end_d  = xe_c;
        y_end_d  = ye_c;
        if (emit_o) begin
            if (col_wrap) begin
                col_d  = x0_c;
                row_d  = row_c + Y_W'(1);
                base_d = base_c + ADDR_W'(H_RES);
            end else begin
                col_d  = col_c + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            x0_q    <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            x0_q    <= x0_d;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
        end
    end

endmodule

// File: rtl/display_fill.sv
// Rectangle fill engine with CPU write priority; writes are registered, one cycle after they are decided.
// The first pixel is written the cycle after acceptance; a CPU write stalls the scan for that cycle.
module display_fill
    import display_fill_pkg::*;
#(
    parameter int H_RES = H_RES_C,
    parameter int V_RES = V_RES_C
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [X_W-1:0]     cmd_x,
    input  logic [Y_W-1:0]     cmd_y,
    input  logic [X_W-1:0]     cmd_w,
    input  logic [Y_W-1:0]     cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic [ADDR_W-1:0]  cpu_waddr,
    input  logic [COLOR_W-1:0] cpu_wdata,
    input  logic               cpu_web,
    output logic [ADDR_W-1:0]  mem_waddr,
    output logic [COLOR_W-1:0] mem_wdata,
    output logic               mem_web,
    output logic               done
);

    fill_state_e        state_q, state_d;
    logic [COLOR_W-1:0] color_q, color_c;
    logic [ADDR_W-1:0]  mem_waddr_q, mem_waddr_d;
    logic [COLOR_W-1:0] mem_wdata_q, mem_wdata_d;
    logic               mem_web_q, mem_web_d;
    logic [EXT_W-1:0]   x_sum, y_sum, x_end, y_end;
    logic               accept, empty, scan_emit, scan_last;
    logic [ADDR_W-1:0]  scan_addr;

    always_comb begin
        x_sum  = EXT_W'(cmd_x) + EXT_W'(cmd_w);
        y_sum  = EXT_W'(cmd_y) + EXT_W'(cmd_h);
        x_end  = (x_sum > EXT_W'(H_RES)) ? EXT_W'(H_RES) : x_sum;
        y_end  = (y_sum > EXT_W'(V_RES)) ? EXT_W'(V_RES) : y_sum;
        empty  = (cmd_w == '0) || (cmd_h == '0) ||
                 (EXT_W'(cmd_x) >= EXT_W'(H_RES)) || (EXT_W'(cmd_y) >= EXT_W'(V_RES));
        accept = cmd_valid && (state_q == IDLE);
    end

    fill_scan #(.H_RES(H_RES)) u_scan (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept && !empty),
        .run_i   (state_q == FILL),
        .stall_i (cpu_web),
        .x_i     (cmd_x),
        .y_i     (cmd_y),
        .x_end_i (x_end),
        .y_end_i (y_end),
        .emit_o  (scan_emit),
        .last_o  (scan_last),
        .addr_o  (scan_addr)
    );

    // A 1x1 fill taken without a stall finishes in its acceptance cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (empty || (scan_emit && scan_last)) ? DONE : FILL;
            FILL: if (scan_emit && scan_last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        color_c     = (accept && !empty) ? cmd_color : color_q;
        mem_web_d   = cpu_web || scan_emit;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        if (cpu_web) begin
            mem_waddr_d = cpu_waddr;
            mem_wdata_d = cpu_wdata;
        end else if (scan_emit) begin
            mem_waddr_d = scan_addr;
            mem_wdata_d = color_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            color_q     <= '0;
            mem_web_q   <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            color_q     <= color_c;
            mem_web_q   <= mem_web_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign mem_web   = mem_web_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_display_fill.sv
// Drives directed and random fill/CPU traffic and compares every cycle against a pixel-queue model.
module tb_display_fill;

    localparam int H = 80;
    localparam int V = 60;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, cpu_web, mem_web, done;
    logic [6:0]  cmd_x, cmd_w;
    logic [5:0]  cmd_y, cmd_h;
    logic [23:0] cmd_color, cpu_wdata, mem_wdata;
    logic [12:0] cpu_waddr, mem_waddr;

    always #5 clk = ~clk;

    display_fill dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_web(cpu_web),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_web(mem_web), .done(done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: phase 0 = ready, 1 = pixels outstanding, 2 = completion cycle.
    int          m_phase = 0;
    int          pq[$];
    logic [23:0] m_color = '0;
    logic        exp_web = 1'b0, exp_done = 1'b0;
    logic [12:0] exp_addr = '0;
    logic [23:0] exp_data = '0;
    bit          armed = 1'b0;
    int          obs_writes = 0;

    task automatic step(input logic r, input logic v, input logic [6:0] x, input logic [5:0] y,
                        input logic [6:0] w, input logic [5:0] h, input logic [23:0] col,
                        input logic cw, input logic [12:0] ca, input logic [23:0] cd);
        int nph, xe, ye;
        if (armed) begin
            chk("cmd_ready", cmd_ready, (m_phase == 0));
            chk("mem_web", mem_web, exp_web);
            chk("mem_waddr", mem_waddr, exp_addr);
            chk("mem_wdata", mem_wdata, exp_data);
            chk("done", done, exp_done);
        end
        if (mem_web === 1'b1) obs_writes++;

        rst = r; cmd_valid = v; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h;
        cmd_color = col; cpu_web = cw; cpu_waddr = ca; cpu_wdata = cd;

        if (r) begin
            m_phase = 0; pq.delete();
            exp_web = 0; exp_addr = '0; exp_data = '0; exp_done = 0;
            armed = 1'b1;
        end else begin
            nph = (m_phase == 2) ? 0 : m_phase;
            if (m_phase == 0 && v) begin
                xe = (int'(x) + int'(w) > H) ? H : int'(x) + int'(w);
                ye = (int'(y) + int'(h) > V) ? V : int'(y) + int'(h);
                if (w != 0 && h != 0 && x < H && y < V)
                    for (int rr = int'(y); rr < ye; rr++)
                        for (int cc = int'(x); cc < xe; cc++)
                            pq.push_back(rr * H + cc);
                m_color = col;
                nph = (pq.size() == 0) ? 2 : 1;
            end
            exp_web = 1'b0;
            if (cw) begin
                exp_web = 1'b1; exp_addr = ca; exp_data = cd;
            end else if (nph == 1) begin
                exp_web = 1'b1; exp_addr = 13'(pq.pop_front()); exp_data = m_color;
                if (pq.size() == 0) nph = 2;
            end
            exp_done = (nph == 2);
            m_phase  = nph;
        end
        @(negedge clk);
    endtask

    task automatic cmd(input logic [6:0] x, input logic [5:0] y, input logic [6:0] w,
                       input logic [5:0] h, input logic [23:0] col);
        step(0, 1, x, y, w, h, col, 0, '0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, '0, '0, 0, '0, '0);
    endtask

    initial begin
        rst = 1; cmd_valid = 0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
        cmd_color = '0; cpu_web = 0; cpu_waddr = '0; cpu_wdata = '0;
        @(negedge clk);
        step(1, 0, '0, '0, '0, '0, '0, 0, '0, '0);
        step(1, 1, 7'd3, 6'd3, 7'd3, 6'd3, 24'h123456, 1, 13'd5, 24'h1);
        idle(2);

        cmd(7'd0, 6'd0, 7'd2, 6'd2, 24'hFF0000);               idle(6);
        cmd(7'd78, 6'd59, 7'd5, 6'd3, 24'h00AA55);             idle(4);
        cmd(7'd5, 6'd5, 7'd0, 6'd4, 24'h0000FF);               idle(3);
        cmd(7'd85, 6'd2, 7'd3, 6'd3, 24'h111111);              idle(3);
        cmd(7'd10, 6'd10, 7'd1, 6'd1, 24'h222222);             idle(3);

        cmd(7'd0, 6'd0, 7'd4, 6'd1, 24'hABCDEF);
        step(0, 0, '0, '0, '0, '0, '0, 1, 13'd100, 24'h00FF00);
        step(0, 1, 7'd9, 6'd9, 7'd9, 6'd9, 24'h999999, 0, '0, '0);
        idle(5);

        cmd(7'd0, 6'd0, 7'd80, 6'd60, 24'h445566);             idle(100);
        step(1, 0, '0, '0, '0, '0, '0, 0, '0, '0);              idle(5);

        obs_writes = 0;
        cmd(7'd0, 6'd0, 7'd80, 6'd60, 24'hC0FFEE);             idle(4802);
        chk("fullscreen_writes", obs_writes, 4800);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 2) == 0),
                 7'($urandom_range(0, 90)), 6'($urandom_range(0, 65)),
                 ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 8)),
                 6'($urandom_range(0, 5)), 24'($urandom()),
                 ($urandom_range(0, 3) == 0), 13'($urandom_range(0, 8191)), 24'($urandom()));
        end
        idle(60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
